sram_vec_add_engine: RTL and testbench

//  Vector-add engine that sits on the initiator side of the team's 2R/1W synchronous SRAM.
//  It computes C[i] = A[i] + B[i] for i = 0..len-1.

---
 rtl/sram_vec_add_engine_if.sv | 36 +++
 rtl/sram_vec_add_engine.sv | 78 +++++++
 tb/tb_sram_vec_add_engine.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_vec_add_engine_if.sv
// sram_vec_add_engine_if: host handshake plus 2R/1W SRAM bus of the vector-add engine
interface sram_vec_add_engine_if #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 4
);
  localparam int ADDR_WIDTH = $clog2(SIZE);
  logic                  i_start;
  logic                  i_hold;
  logic [ADDR_WIDTH-1:0] i_base_a;
  logic [ADDR_WIDTH-1:0] i_base_b;
  logic [ADDR_WIDTH-1:0] i_base_c;
  logic [ADDR_WIDTH:0]   i_len;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_overflow;
  logic                  o_mem_en;
  logic                  o_mem_r1;
  logic                  o_mem_r2;
  logic                  o_mem_w;
  logic [ADDR_WIDTH-1:0] o_mem_r1_addr;
  logic [ADDR_WIDTH-1:0] o_mem_r2_addr;
  logic [ADDR_WIDTH-1:0] o_mem_w_addr;
  logic [WIDTH-1:0]      o_mem_wdata;
  logic [WIDTH-1:0]      i_mem_rdata1;
  logic [WIDTH-1:0]      i_mem_rdata2;
  modport master (
    output i_start, i_hold, i_base_a, i_base_b, i_base_c, i_len, i_mem_rdata1, i_mem_rdata2,
    input  o_busy, o_done, o_overflow, o_mem_en, o_mem_r1, o_mem_r2, o_mem_w,
    input  o_mem_r1_addr, o_mem_r2_addr, o_mem_w_addr, o_mem_wdata
  );
  modport slave (
    input  i_start, i_hold, i_base_a, i_base_b, i_base_c, i_len, i_mem_rdata1, i_mem_rdata2,
    output o_busy, o_done, o_overflow, o_mem_en, o_mem_r1, o_mem_r2, o_mem_w,
    output o_mem_r1_addr, o_mem_r2_addr, o_mem_w_addr, o_mem_wdata
  );
endinterface

// File: rtl/sram_vec_add_engine.sv
// sram_vec_add_engine: streams C[i] = A[i] + B[i] through a 2R/1W synchronous SRAM
module sram_vec_add_engine #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  sram_vec_add_engine_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(SIZE);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base_a;
  logic [ADDR_WIDTH-1:0] r_base_b;
  logic [ADDR_WIDTH-1:0] r_base_c;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_rd_idx;
  logic                  r_overflow;
  logic                  w_accept;
  logic                  w_adv;
  logic                  w_last;
  logic                  w_wr;
  logic [ADDR_WIDTH:0]   w_wr_idx;
  logic [WIDTH:0]        w_sum;
  // The element written in a cycle is always the one read in the previous active cycle,
  // so the write index is derived from the read index instead of being stored.
  assign w_accept = r_state == IDLE && bus.i_start;
  assign w_adv    = (r_state == RUN || r_state == DRAIN) && !bus.i_hold && !rst;
  assign w_last   = r_rd_idx == r_len - (ADDR_WIDTH+1)'(1);
  assign w_wr_idx = r_rd_idx - (ADDR_WIDTH+1)'(1);
  assign w_wr     = w_adv && (r_state == DRAIN || r_rd_idx != '0);
  assign w_sum    = {1'b0, bus.i_mem_rdata1} + {1'b0, bus.i_mem_rdata2};
  // State register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // Next-state logic; hold freezes RUN and DRAIN
  always_comb begin
    w_next = r_state == IDLE  ? (bus.i_start ? (bus.i_len != '0 ? RUN : DONE) : IDLE) :
             r_state == RUN   ? (w_adv && w_last ? DRAIN : RUN) :
             r_state == DRAIN ? (w_adv ? DONE : DRAIN) : IDLE;
  end
  // Outputs; gated by rst so a reset cycle never issues a strobe or a partial write
  always_comb begin
    bus.o_busy        = !rst && (r_state == RUN || r_state == DRAIN);
    bus.o_done        = !rst && r_state == DONE;
    bus.o_overflow    = !rst && r_overflow;
    bus.o_mem_en      = w_adv;
    bus.o_mem_r1      = w_adv && r_state == RUN;
    bus.o_mem_r2      = w_adv && r_state == RUN;
    bus.o_mem_w       = w_wr;
    bus.o_mem_r1_addr = r_base_a + r_rd_idx[ADDR_WIDTH-1:0];
    bus.o_mem_r2_addr = r_base_b + r_rd_idx[ADDR_WIDTH-1:0];
    bus.o_mem_w_addr  = r_base_c + w_wr_idx[ADDR_WIDTH-1:0];
    bus.o_mem_wdata   = w_sum[WIDTH-1:0];
  end
  // Operand latching, read index advance and sticky carry-out accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_base_c   <= '0;
      r_len      <= '0;
      r_rd_idx   <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_base_a   <= bus.i_base_a;
      r_base_b   <= bus.i_base_b;
      r_base_c   <= bus.i_base_c;
      r_len      <= bus.i_len;
      r_rd_idx   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_adv && r_state == RUN) r_rd_idx <= r_rd_idx + (ADDR_WIDTH+1)'(1);
      if (w_wr && w_sum[WIDTH]) r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_vec_add_engine.sv
// tb_sram_vec_add_engine: directed and randomized checks of the vector-add engine against a plain arithmetic model
module tb_sram_vec_add_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sram_vec_add_engine_if #(.SIZE(16), .WIDTH(4)) vif ();
  sram_vec_add_engine #(.SIZE(16), .WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(vif));
  logic [3:0] mem [16];
  logic [3:0] img [16];
  logic       ld = 1'b0;
  logic [3:0] rd_log [$];
  int model_mem [16];
  int model_ovf;
  int checks = 0;
  int errors = 0;
  int dc, viol, held, ens, bsy, rd0;
  // Behavioural 2R/1W SRAM: registered reads, read-before-write, outputs held while en=0
  always @(posedge clk) begin
    if (ld) mem <= img;
    else if (vif.o_mem_en) begin
      if (vif.o_mem_r1) begin
        vif.i_mem_rdata1 <= mem[vif.o_mem_r1_addr];
        rd_log.push_back(vif.o_mem_r1_addr);
      end
      if (vif.o_mem_r2) vif.i_mem_rdata2 <= mem[vif.o_mem_r2_addr];
      if (vif.o_mem_w) mem[vif.o_mem_w_addr] <= vif.o_mem_wdata;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_load();
    for (int i = 0; i < 16; i++) model_mem[i] = int'(img[i]);
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask
  // Element-by-element reference; valid for disjoint regions and exact in-place operation
  task automatic model_add(input int a, input int b, input int c, input int l);
    model_ovf = 0;
    for (int i = 0; i < l; i++) begin
      int s;
      s = model_mem[(a + i) % 16] + model_mem[(b + i) % 16];
      model_mem[(c + i) % 16] = s % 16;
      if (s > 15) model_ovf = 1;
    end
  endtask
  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), int'(mem[i]), model_mem[i]);
  endtask
  // Cycle 0 = the cycle start is presented; returns the cycle index where done was seen
  task automatic run_op(input int a, input int b, input int c, input int l, input int hmode,
                        input int hs, input int hn, input int rs,
                        output int o_dc, output int o_viol, output int o_held, output int o_ens, output int o_bsy);
    o_dc = -1; o_viol = 0; o_held = 0; o_ens = 0; o_bsy = 0;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      vif.i_start = (cyc == 0) || (cyc == rs);
      if (cyc == 0) begin
        vif.i_base_a = 4'(a); vif.i_base_b = 4'(b); vif.i_base_c = 4'(c); vif.i_len = 5'(l);
      end else begin
        vif.i_base_a = 4'($urandom); vif.i_base_b = 4'($urandom); vif.i_base_c = 4'($urandom);
        vif.i_len = 5'($urandom_range(16));
      end
      vif.i_hold = hmode == 1 ? (cyc >= hs && cyc < hs + hn) : hmode == 2 ? (cyc > 0 && $urandom_range(3) == 0) : 1'b0;
      @(negedge clk);
      if (vif.o_busy) o_bsy++;
      if (vif.o_mem_en) o_ens++;
      if (vif.i_hold && vif.o_busy) begin
        o_held++;
        if (vif.o_mem_en || vif.o_mem_r1 || vif.o_mem_r2 || vif.o_mem_w) o_viol++;
      end
      if (vif.o_done) begin
        o_dc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    vif.i_start = 1'b0;
    vif.i_hold = 1'b0;
  endtask
  initial begin
    vif.i_start = 1'b0; vif.i_hold = 1'b0; vif.i_len = '0;
    vif.i_base_a = '0; vif.i_base_b = '0; vif.i_base_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", vif.o_busy, 0);
    chk("rst_done", vif.o_done, 0);
    chk("rst_ovf", vif.o_overflow, 0);
    chk("rst_en", vif.o_mem_en, 0);
    rst = 1'b0;
    // Basic add
    for (int i = 0; i < 16; i++) img[i] = 4'd0;
    for (int i = 0; i < 4; i++) begin img[i] = 4'(i + 1); img[4 + i] = 4'd5; end
    do_load();
    model_add(0, 4, 8, 4);
    run_op(0, 4, 8, 4, 0, 0, 0, -1, dc, viol, held, ens, bsy);
    chk("basic_done_cyc", dc, 6);
    chk("basic_ovf", vif.o_overflow, 0);
    chk("basic_c0", int'(mem[8]), 6);
    chk("basic_c3", int'(mem[11]), 9);
    check_mem("basic");
    // Overflow and address wrap
    for (int i = 0; i < 16; i++) img[i] = 4'd1;
    img[14] = 4'd9; img[2] = 4'd8;
    do_load();
    model_add(14, 2, 6, 4);
    rd0 = rd_log.size();
    run_op(14, 2, 6, 4, 0, 0, 0, -1, dc, viol, held, ens, bsy);
    chk("wrap_done_cyc", dc, 6);
    chk("wrap_ovf", vif.o_overflow, 1);
    chk("wrap_c0", int'(mem[6]), 1);
    chk("wrap_nreads", rd_log.size() - rd0, 4);
    chk("wrap_rd0", int'(rd_log[rd0]), 14);
    chk("wrap_rd1", int'(rd_log[rd0 + 1]), 15);
    chk("wrap_rd2", int'(rd_log[rd0 + 2]), 0);
    chk("wrap_rd3", int'(rd_log[rd0 + 3]), 1);
    check_mem("wrap");
    repeat (3) @(negedge clk);
    chk("ovf_sticky_idle", vif.o_overflow, 1);
    // Reset mid-RUN with overflow already set
    for (int i = 0; i < 16; i++) img[i] = 4'd15;
    do_load();
    @(posedge clk);
    #1;
    vif.i_start = 1'b1; vif.i_base_a = 4'd0; vif.i_base_b = 4'd4; vif.i_base_c = 4'd8; vif.i_len = 5'd8;
    @(posedge clk);
    #1;
    vif.i_start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_busy", vif.o_busy, 1);
    chk("pre_rst_ovf", vif.o_overflow, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_w", k), vif.o_mem_w, 0);
      chk($sformatf("rst%0d_busy", k), vif.o_busy, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", vif.o_busy, 0);
    chk("post_rst_done", vif.o_done, 0);
    chk("post_rst_ovf", vif.o_overflow, 0);
    chk("post_rst_en", vif.o_mem_en, 0);
    // Hold for 3 cycles from cycle 3
    for (int i = 0; i < 16; i++) img[i] = 4'd0;
    for (int i = 0; i < 4; i++) begin img[i] = 4'(i + 1); img[4 + i] = 4'd5; end
    do_load();
    model_add(0, 4, 8, 4);
    run_op(0, 4, 8, 4, 1, 3, 3, -1, dc, viol, held, ens, bsy);
    chk("hold_done_cyc", dc, 9);
    chk("hold_strobes", viol, 0);
    chk("hold_cycles", held, 3);
    check_mem("hold");
    // len = 0
    run_op(3, 5, 7, 0, 0, 0, 0, -1, dc, viol, held, ens, bsy);
    chk("len0_done_cyc", dc, 1);
    chk("len0_busy", bsy, 0);
    chk("len0_en", ens, 0);
    check_mem("len0");
    // In place over the whole memory
    for (int i = 0; i < 16; i++) img[i] = 4'($urandom);
    do_load();
    model_add(0, 0, 0, 16);
    run_op(0, 0, 0, 16, 0, 0, 0, -1, dc, viol, held, ens, bsy);
    chk("inplace_done_cyc", dc, 18);
    chk("inplace_ovf", vif.o_overflow, model_ovf);
    check_mem("inplace");
    // Start while busy is ignored, then a back-to-back start right after DONE
    for (int i = 0; i < 16; i++) img[i] = 4'($urandom);
    do_load();
    model_add(0, 4, 8, 4);
    run_op(0, 4, 8, 4, 0, 0, 0, 2, dc, viol, held, ens, bsy);
    chk("busy_start_done_cyc", dc, 6);
    chk("busy_start_ovf", vif.o_overflow, model_ovf);
    model_add(12, 13, 14, 1);
    run_op(12, 13, 14, 1, 0, 0, 0, -1, dc, viol, held, ens, bsy);
    chk("b2b_done_cyc", dc, 3);
    chk("b2b_ovf", vif.o_overflow, model_ovf);
    check_mem("b2b");
    // Randomized disjoint operations with random hold
    for (int t = 0; t < 8; t++) begin
      int r, l;
      r = $urandom_range(15);
      l = $urandom_range(5, 1);
      for (int i = 0; i < 16; i++) img[i] = 4'($urandom);
      do_load();
      model_add(r, (r + 5) % 16, (r + 10) % 16, l);
      run_op(r, (r + 5) % 16, (r + 10) % 16, l, 2, 0, 0, -1, dc, viol, held, ens, bsy);
      chk($sformatf("rnd%0d_done_cyc", t), dc, l + 2 + held);
      chk($sformatf("rnd%0d_hold_strobes", t), viol, 0);
      chk($sformatf("rnd%0d_en", t), ens, l + 1);
      chk($sformatf("rnd%0d_ovf", t), vif.o_overflow, model_ovf);
      check_mem($sformatf("rnd%0d", t));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
